// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor built around one full-subtractor cell
//
// Optional feature macro: SERIAL_SUB_OVF_EN (adds the ovf output).
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, honoured only while busy=0
//   a      in   WIDTH  minuend, captured on the accepted start edge
//   b      in   WIDTH  subtrahend, captured on the accepted start edge
//   bin    in   1      initial borrow-in, captured on the accepted start edge
//   busy   out  1      high while bits are being shifted
//   done   out  1      one-cycle pulse when diff/bout are updated
//   diff   out  WIDTH  a - b - bin (mod 2^WIDTH), held until the next result
//   bout   out  1      final borrow-out, held until the next result
//   ovf    out  1      two's-complement overflow (SERIAL_SUB_OVF_EN only)
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] r_next;

    // Full-subtractor cell fed from the operand LSBs and the borrow flop.
    assign cell_diff = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    assign cell_bout = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_r_w1
            assign r_next = cell_diff;
        end else begin : g_r_wn
            assign r_next = {cell_diff, r_sh_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside because the shift registers lose them.
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        r_sh_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                S_SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    r_sh_q <= r_next;
                    brw_q  <= cell_bout;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        diff_q  <= r_next;
                        bout_q  <= cell_bout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`ifdef SERIAL_SUB_OVF_EN
                        // cell_diff is the result MSB on the last bit.
                        ovf_q <= (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (WIDTH=8 and WIDTH=1 instances)
module tb_serial_sub;

    logic       clk;
    logic       rst_n;

    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    int checks;
    int failures;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf8),
`endif
        .bout  (bout8)
    );

    serial_sub #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf1),
`endif
        .bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operands.
    task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          output logic [7:0] d, output logic bo, output logic ov);
        int r;
        int s;
        r  = int'(a) - int'(b) - int'(bi);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        d  = r[7:0];
        bo = (r < 0);
        ov = (s > 127) || (s < -128);
    endtask

    // Starts one WIDTH=8 operation and returns edges from acceptance to done (-1 on timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        lat = 0;
        while (done8 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done8 !== 1'b1) lat = -1;
    endtask

    task automatic run1(input logic a, input logic b, input logic bi, output int lat);
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b; bin1 = bi;
        @(posedge clk); #1;
        start1 = 1'b0; a1 = ~a; b1 = ~b; bin1 = ~bi;
        lat = 0;
        while (done1 !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done1 !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        #23;
        checks++;
        if ({busy8, done8, diff8, bout8} !== 11'd0) begin
            failures++;
            $display("FAIL reset_w8 got busy=%b done=%b diff=%h bout=%b want all 0", busy8, done8, diff8, bout8);
        end
        checks++;
        if ({busy1, done1, diff1, bout1} !== 4'd0) begin
            failures++;
            $display("FAIL reset_w1 got busy=%b done=%b diff=%h bout=%b want all 0", busy1, done1, diff1, bout1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [7:0] va [3] = '{8'h05, 8'h00, 8'h10};
        logic [7:0] vb [3] = '{8'h03, 8'h01, 8'h0F};
        logic       vi [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] wd [3] = '{8'h02, 8'hFF, 8'h00};
        logic       wb [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], vi[i], lat);
            checks++;
            if (lat !== 8) begin
                failures++;
                $display("FAIL directed_latency[%0d] got %0d want 8", i, lat);
            end
            checks++;
            if (diff8 !== wd[i] || bout8 !== wb[i] || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL directed_result[%0d] got diff=%h bout=%b busy=%b want diff=%h bout=%b busy=0",
                         i, diff8, bout8, busy8, wd[i], wb[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] a, b, d;
        logic bi, bo, ov;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
            model8(a, b, bi, d, bo, ov);
            run8(a, b, bi, lat);
            checks++;
            if (lat !== 8 || diff8 !== d || bout8 !== bo) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h bin=%b got lat=%0d diff=%h bout=%b want lat=8 diff=%h bout=%b",
                         i, a, b, bi, lat, diff8, bout8, d, bo);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ovf8 !== ov) begin
                failures++;
                $display("FAIL random_ovf[%0d] a=%h b=%h bin=%b got %b want %b", i, a, b, bi, ovf8, ov);
            end
`endif
        end
    endtask

    task automatic test_busy_ignore;
        int n_done;
        int first_done;
        int bad_busy;
        n_done = 0; first_done = -1; bad_busy = 0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 3 || cyc == 5) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc < 8 && busy8 !== 1'b1) bad_busy++;
            if (cyc < 8 && diff8 === 8'h22) bad_busy++;
            if (done8 === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
        end
        checks++;
        if (n_done !== 1 || first_done !== 8) begin
            failures++;
            $display("FAIL busy_ignore_done got count=%0d at=%0d want count=1 at=8", n_done, first_done);
        end
        checks++;
        if (bad_busy !== 0) begin
            failures++;
            $display("FAIL busy_ignore_busy got %0d bad cycles want 0", bad_busy);
        end
        checks++;
        if (diff8 !== 8'h22 || bout8 !== 1'b0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_result got diff=%h bout=%b busy=%b want diff=22 bout=0 busy=0",
                     diff8, bout8, busy8);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run8(8'h05, 8'h03, 1'b0, lat);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h20; b8 = 8'h01; bin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || diff8 !== 8'h02 || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b diff=%h bout=%b want busy=1 diff=02 bout=0", busy8, diff8, bout8);
        end
        lat = 0;
        while (done8 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (done8 !== 1'b1 || lat !== 8 || diff8 !== 8'h1E || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result got lat=%0d diff=%h bout=%b want lat=8 diff=1e bout=0", lat, diff8, bout8);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int n_done;
        run8(8'h00, 8'h01, 1'b0, lat);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, diff8, bout8} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b diff=%h bout=%b want all 0", busy8, done8, diff8, bout8);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ovf got %b want 0", ovf8);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got %0d active cycles want 0", n_done);
        end
    endtask

    task automatic test_width1;
        logic ta, tb, ti;
        logic [0:0] wd;
        logic wb;
        int r;
        int lat;
        for (int i = 0; i < 8; i++) begin
            ta = 1'(i >> 2); tb = 1'(i >> 1); ti = 1'(i);
            r  = int'(ta) - int'(tb) - int'(ti);
            wd = r[0:0];
            wb = (r < 0);
            run1(ta, tb, ti, lat);
            checks++;
            if (lat !== 1 || diff1 !== wd || bout1 !== wb) begin
                failures++;
                $display("FAIL width1[%0d] a=%b b=%b bin=%b got lat=%0d diff=%b bout=%b want lat=1 diff=%b bout=%b",
                         i, ta, tb, ti, lat, diff1, bout1, wd, wb);
            end
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int lat;
        run8(8'h80, 8'h01, 1'b0, lat);
        checks++;
        if (diff8 !== 8'h7F || ovf8 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got diff=%h ovf=%b want diff=7f ovf=1", diff8, ovf8);
        end
        run8(8'h05, 8'h03, 1'b0, lat);
        checks++;
        if (diff8 !== 8'h02 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got diff=%h ovf=%b want diff=02 ovf=0", diff8, ovf8);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_directed;
        test_random;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_width1;
`ifdef SERIAL_SUB_OVF_EN
        test_ovf;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
